mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the word-addressed data memory. Turns CPU load/store requests into word-level memory reads and writes.
- Request sizes: byte, half and word, with sign/zero extension on loads.
- Sub-word stores use a read-modify-write sequence, because the memory only writes full words.
- Sits between the MEM-stage request logic and the data memory; drives the stall/ready handshake back to the pipeline.

Parameters:
ADDR_W, 12, width of the memory word index.
DEPTH, 3072, number of 32-bit words in the memory; word indices >= DEPTH are out of range.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
req_sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-aligned.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  32  load result; valid while resp_valid is high.
resp_err  output  1  error flag for misaligned, out-of-range or illegal-size requests; qualified by resp_valid.
mem_addr  output  ADDR_W  word index to the memory.
mem_we  output  1  memory write enable.
mem_wdata  output  32  full-word write data.
mem_rdata  input  32  memory read data, combinational from mem_addr.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. The ports are named clk and reset.
- Reset values: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_we=0; mem_addr=0; mem_wdata=0.
- Reset mid-operation: abort immediately and return to IDLE. mem_we drops asynchronously, so no partial write occurs.
- States:
  - IDLE: req_ready=1. A request is accepted when req_valid&&req_ready. On accept, latch we, size, sign, addr[1:0], word index = addr[ADDR_W+1:2] and wdata.
  - Transitions out of IDLE on accept:
    - Load, or sub-word store → READ.
    - Word store → WRITE.
    - Error request → ERR.
  - READ: req_ready=0; mem_addr = latched index; mem_we=0.
    - Load: extract the lane, extend it, register it into resp_rdata, then go to IDLE with resp_valid=1 next cycle.
    - Sub-word store: register merged = (mem_rdata & ~mask) | ((wdata << 8*lane) & mask), then go to WRITE.
  - WRITE: req_ready=0; mem_addr = index; mem_we=1; mem_wdata = merged word, or wdata for a word store. Go to IDLE with resp_valid=1 next cycle; resp_rdata is unchanged.
  - ERR: req_ready=0; no memory access (mem_we=0). Go to IDLE with resp_valid=1 and resp_err=1 next cycle.
- Lane and mask rules:
  - Byte: lane = addr[1:0]; mask = 0xFF << 8*lane.
  - Half: lane = {addr[1],0}; mask = 0xFFFF << 8*lane.
  - Word: mask = 0xFFFFFFFF.
- Error conditions:
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - size=3;
  - word index >= DEPTH;
  - addr[31:ADDR_W+2]≠0.
- resp_valid / resp_err: a single-cycle pulse, asserted in the IDLE cycle that follows completion. A new request may be accepted in that same cycle, giving back-to-back throughput.
- Latency, from acceptance to resp_valid:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 2 cycles.
- Held inputs: req_* inputs may change freely after acceptance, because all request fields are latched.
- Ordering: strictly one outstanding request. A load that follows a store always sees the stored data, because the write commits before the next acceptance.

Decomposition:
- Shared package contents:
  - size encodings: SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - state enum: IDLE, READ, WRITE, ERR;
  - the DEPTH default.
- One natural sub-module, lane_align: a combinational mask/shift/extend helper used for both load extraction and store merge.

Test Plan:
- Word store then load:
  - store addr 0x10, data 0xDEADBEEF → mem_we=1 with mem_addr=4 for one cycle, then resp_valid.
  - load word 0x10 → resp_rdata=0xDEADBEEF, 2 cycles after accept.
- Byte store RMW:
  - word 4 holds 0xDEADBEEF; store byte addr 0x11, data 0x55 → READ, then WRITE with mem_wdata=0xDEAD55EF.
  - resp_valid 3 cycles after accept.
- Sign/zero extend:
  - word 4 holds 0xDEAD55EF.
  - load byte addr 0x13, sign=1 → 0xFFFFFFDE.
  - load half addr 0x12, sign=0 → 0x0000DEAD.
- Errors:
  - load word addr 0x12 → resp_err=1, no mem_we.
  - store half addr 0x13 → resp_err=1, memory unchanged.
  - load addr 0x3000 (index 3072) → resp_err=1.
- Back-to-back: hold req_valid=1 across 4 word stores → each is accepted in the cycle its predecessor's resp_valid pulses; no request is dropped.
- Reset mid-RMW: assert reset during the READ of a byte store → mem_we stays 0, the word is unchanged, and after release req_ready=1 and resp_valid=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: request sizes, FSM states and
// the default memory depth.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int DEPTH_DEFAULT = 3072;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane helper: extracts and extends a load lane from a memory
// word, and merges sub-word store data into a memory word.
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shift_s;
  logic [31:0] mask_s;
  logic [31:0] raw_s;

  // Lane bit offset and byte-enable mask for the request size
  always_comb begin
    shift_s = 5'd0;
    mask_s  = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: begin
        shift_s = {offset, 3'b000};
        mask_s  = 32'h0000_00FF << shift_s;
      end
      SZ_HALF: begin
        shift_s = {offset[1], 1'b0, 3'b000};
        mask_s  = 32'h0000_FFFF << shift_s;
      end
      default: begin
        shift_s = 5'd0;
        mask_s  = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign raw_s = rdata >> shift_s;

  // Sign or zero extension of the selected lane
  always_comb begin
    load_data = raw_s;
    case (size)
      SZ_BYTE: load_data = {{24{sign & raw_s[7]}}, raw_s[7:0]};
      SZ_HALF: load_data = {{16{sign & raw_s[15]}}, raw_s[15:0]};
      default: load_data = raw_s;
    endcase
  end

  assign merged = (rdata & ~mask_s) | ((wdata << shift_s) & mask_s);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only data memory: sub-word stores become a
// read-modify-write, loads are lane-extracted and extended.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t state_r;
  state_t next_s;

  logic              we_r;
  logic              sign_r;
  logic [1:0]        size_r;
  logic [1:0]        offset_r;
  logic [ADDR_W-1:0] idx_r;
  logic [31:0]       wdata_r;

  logic [ADDR_W-1:0] idx_s;
  logic              size_err_s;
  logic              range_err_s;
  logic              err_s;
  logic [31:0]       load_s;
  logic [31:0]       merged_s;

  assign idx_s       = req_addr[ADDR_W+1:2];
  assign range_err_s = (32'(idx_s) >= 32'(DEPTH)) ||
                       (req_addr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});
  assign err_s       = size_err_s | range_err_s;

  // Alignment and size legality of the incoming request
  always_comb begin
    size_err_s = 1'b0;
    case (req_size)
      SZ_BYTE: size_err_s = 1'b0;
      SZ_HALF: size_err_s = req_addr[0];
      SZ_WORD: size_err_s = (req_addr[1:0] != 2'b00);
      default: size_err_s = 1'b1;
    endcase
  end

  mem_access_unit_lane_align u_lane_align (
    .size      (size_r),
    .sign      (sign_r),
    .offset    (offset_r),
    .rdata     (mem_rdata),
    .wdata     (wdata_r),
    .load_data (load_s),
    .merged    (merged_s)
  );

  // Next-state and state-decoded handshake/memory strobes
  always_comb begin
    next_s    = state_r;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    case (state_r)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (err_s) begin
            next_s = ERR;
          end else if (req_we && (req_size == SZ_WORD)) begin
            next_s = WRITE;
          end else begin
            next_s = READ;
          end
        end else begin
          next_s = IDLE;
        end
      end
      READ: begin
        if (we_r) begin
          next_s = WRITE;
        end else begin
          next_s = IDLE;
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        next_s = IDLE;
      end
      ERR:     next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  assign mem_addr  = idx_r;
  assign mem_wdata = wdata_r;

  // State register, request latch, merge capture and response pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      we_r       <= 1'b0;
      sign_r     <= 1'b0;
      size_r     <= SZ_BYTE;
      offset_r   <= 2'b00;
      idx_r      <= {ADDR_W{1'b0}};
      wdata_r    <= 32'h0000_0000;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0000_0000;
    end else begin
      state_r    <= next_s;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            we_r     <= req_we;
            sign_r   <= req_sign;
            size_r   <= req_size;
            offset_r <= req_addr[1:0];
            idx_r    <= idx_s;
            wdata_r  <= req_wdata;
          end
        end
        READ: begin
          // A store reuses the wdata register to hold the merged word
          if (we_r) begin
            wdata_r <= merged_s;
          end else begin
            resp_rdata <= load_s;
            resp_valid <= 1'b1;
          end
        end
        WRITE: resp_valid <= 1'b1;
        ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end
        default: resp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, hand sequences for
// back-to-back and reset-during-RMW, and random requests against a byte model.
module tb_mem_access_unit;

  localparam int DEPTH = 3072;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int cyc = 0;
  logic [11:0] last_waddr = 12'd0;
  logic [31:0] last_wdata = 32'd0;

  mem_access_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_sign   (req_sign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      last_waddr    <= mem_addr;
      last_wdata    <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-level reference: legality by divisibility, data by per-byte moves
  task automatic model_req(input logic we, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic err, output int lat);
    int n, off, idx;
    logic [31:0] w, bm;
    n   = 1 << size;
    off = int'(addr % 4);
    rd  = 32'd0;
    lat = 2;
    err = (size == 2'd3) || ((addr % n) != 0) || (addr >= LIMIT);
    if (!err) begin
      idx = int'(addr >> 2);
      w   = ref_mem[idx];
      if (we) begin
        for (int j = 0; j < n; j++) begin
          bm = 32'hFF << (8 * (off + j));
          w  = (w & ~bm) | (((wdata >> (8 * j)) & 32'hFF) << (8 * (off + j)));
        end
        ref_mem[idx] = w;
        if (n < 4) lat = 3;
      end else begin
        for (int j = 0; j < n; j++)
          rd = rd | (((w >> (8 * (off + j))) & 32'hFF) << (8 * j));
        if (sign && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic err, output int lat);
    int g;
    @(negedge clk);
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    req_we    = we;
    req_size  = size;
    req_sign  = sign;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = $urandom_range(0, 1) == 1;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1;
    rd  = 32'd0;
    err = 1'b0;
    while (lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
      if (resp_valid) begin
        rd  = resp_rdata;
        err = resp_err;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt[15];

  task automatic run_checked(input string tag, input logic we, input logic [1:0] size,
                             input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] rd, mrd;
    logic err, merr;
    int lat, mlat, w0;
    model_req(we, size, sign, addr, wdata, mrd, merr, mlat);
    w0 = wr_cnt;
    do_req(we, size, sign, addr, wdata, rd, err, lat);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (!we && !exp_err) check({tag, "_rdata"}, rd, exp_rd);
    if (we && !exp_err) begin
      check({tag, "_wrcnt"}, 32'(wr_cnt - w0), 32'd1);
      check({tag, "_waddr"}, 32'(last_waddr), 32'(addr[13:2]));
      check({tag, "_wdata"}, last_wdata, ref_mem[addr[13:2]]);
    end
    if (exp_err) check({tag, "_nowrite"}, 32'(wr_cnt - w0), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, mrd, a, d;
    logic err, merr, we, sg;
    logic [1:0] sz;
    int lat, mlat, g, w0;
    int acc_cyc[4];

    for (int i = 0; i < 4096; i++) begin
      mem[i]     <= 32'd0;
      ref_mem[i] = 32'd0;
    end
    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_sign = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2};
    vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2};
    vt[2]  = '{1'b1, 2'd0, 1'b0, 32'h11,   32'h55,       32'h0,        1'b0, 3};
    vt[3]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0, 2};
    vt[4]  = '{1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0, 2};
    vt[5]  = '{1'b0, 2'd1, 1'b0, 32'h12,   32'h0,        32'h0000DEAD, 1'b0, 2};
    vt[6]  = '{1'b0, 2'd2, 1'b0, 32'h12,   32'h0,        32'h0,        1'b1, 2};
    vt[7]  = '{1'b1, 2'd1, 1'b0, 32'h13,   32'h7777,     32'h0,        1'b1, 2};
    vt[8]  = '{1'b0, 2'd2, 1'b0, 32'h3000, 32'h0,        32'h0,        1'b1, 2};
    vt[9]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0, 2};
    vt[10] = '{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1, 2};
    vt[11] = '{1'b0, 2'd2, 1'b0, 32'h10010, 32'h0,       32'h0,        1'b1, 2};
    vt[12] = '{1'b1, 2'd1, 1'b0, 32'h12,   32'h1234ABCD, 32'h0,        1'b0, 3};
    vt[13] = '{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        32'hFFFFABCD, 1'b0, 2};
    vt[14] = '{1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0,        32'h0,        1'b0, 2};

    for (int i = 0; i < 15; i++)
      run_checked($sformatf("vec%0d", i), vt[i].we, vt[i].size, vt[i].sign, vt[i].addr,
                  vt[i].wdata, vt[i].exp_rd, vt[i].exp_err, vt[i].exp_lat);
    check("vec_mem_word4", mem[4], 32'hABCD55EF);

    // Back-to-back word stores with req_valid held high
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g = 0;
      while (!req_ready && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (i > 0) check("b2b_resp_at_accept", 32'(resp_valid), 32'd1);
      a = 32'h40 + 32'(4 * i);
      d = $urandom;
      model_req(1'b1, 2'd2, 1'b0, a, d, mrd, merr, mlat);
      req_we = 1'b1;
      req_size = 2'd2;
      req_sign = 1'b0;
      req_addr = a;
      req_wdata = d;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      acc_cyc[i] = cyc;
    end
    req_valid = 1'b0;
    g = 0;
    while (!resp_valid && g < 10) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("b2b_last_resp", 32'(resp_valid), 32'd1);
    for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
    check("b2b_wrcnt", 32'(wr_cnt - w0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      a = 32'h40 + 32'(4 * i);
      model_req(1'b0, 2'd2, 1'b0, a, 32'd0, mrd, merr, mlat);
      do_req(1'b0, 2'd2, 1'b0, a, 32'd0, rd, err, lat);
      check("b2b_readback", rd, mrd);
    end

    // Reset asserted while a byte store sits in READ
    w0 = wr_cnt;
    @(negedge clk);
    req_we = 1'b1;
    req_size = 2'd0;
    req_sign = 1'b0;
    req_addr = 32'h11;
    req_wdata = 32'hAA;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rmw_busy", 32'(req_ready), 32'd0);
    #1 reset = 1'b1;
    #1;
    check("rmw_rst_mem_we", 32'(mem_we), 32'd0);
    check("rmw_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rmw_rst_nowrite", 32'(wr_cnt - w0), 32'd0);
    check("rmw_rst_word", mem[4], ref_mem[4]);
    check("rmw_rst_ready_after", 32'(req_ready), 32'd1);
    check("rmw_rst_resp_valid", 32'(resp_valid), 32'd0);
    model_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, mrd, merr, mlat);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, err, lat);
    check("rmw_rst_readback", rd, mrd);

    // Randomized requests against the byte model
    for (int i = 0; i < 300; i++) begin
      g = $urandom_range(0, 9);
      if (g < 7) a = 32'($urandom_range(0, 127));
      else if (g < 9) a = 32'h2FF0 + 32'($urandom_range(0, 31));
      else a = $urandom;
      sz = ($urandom_range(0, 9) < 9) ? 2'($urandom_range(0, 2)) : 2'd3;
      we = $urandom_range(0, 1) == 1;
      sg = $urandom_range(0, 1) == 1;
      d  = $urandom;
      model_req(we, sz, sg, a, d, mrd, merr, mlat);
      w0 = wr_cnt;
      do_req(we, sz, sg, a, d, rd, err, lat);
      check("rnd_err", 32'(err), 32'(merr));
      check("rnd_lat", 32'(lat), 32'(mlat));
      if (!we && !merr) check("rnd_rdata", rd, mrd);
      if (we && !merr) check("rnd_wrcnt", 32'(wr_cnt - w0), 32'd1);
      if (merr) check("rnd_nowrite", 32'(wr_cnt - w0), 32'd0);
    end
    for (int i = 0; i < 32; i++) check("final_mem_low", mem[i], ref_mem[i]);
    for (int i = 3068; i < 3072; i++) check("final_mem_top", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
